// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: a free-running double-dabble converter feeds a scanned digit display.
// Define SEG_LZ_BLANK_EN to build leading-zero blanking; otherwise leading zeros are shown.
module seg_scan_display #(
  parameter int DIGITS   = 4,
  parameter int WIDTH    = 16,
  parameter int DIV_BITS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  in,
  input  logic [DIGITS-1:0] dp_mask,
  output logic [7:0]        out,
  output logic [DIGITS-1:0] sel,
  output logic              overflow,
  output logic [1:0]        dbg_state
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] LIMIT = pow10(DIGITS) - 64'd1;

  // Segment pattern for bits 6..0 (g..a), active low; non-decimal nibbles are dark.
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  typedef enum logic [1:0] {
    S_LOAD   = 2'd0,
    S_SHIFT  = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic                load_en, shift_en, commit_en;
  logic [WIDTH-1:0]    bin, samp;
  logic [BCD_W-1:0]    bcd, bcd_adj, disp, disp_nxt;
  logic [CNT_W-1:0]    cnt;
  logic                ovf_nxt;
  logic [DIV_BITS-1:0] pre;
  logic                tick;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [3:0]          nib;
  logic [6:0]          seg;
  logic [7:0]          out_nxt;
  logic [DIGITS-1:0]   sel_nxt;

  // Converter FSM: state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_LOAD;
    else      state <= state_nxt;
  end

  // Converter FSM: next state (no idle state, it loops forever)
  always_comb begin
    state_nxt = S_LOAD;
    case (state)
      S_LOAD:   state_nxt = S_SHIFT;
      S_SHIFT:  state_nxt = (cnt == CNT_W'(1)) ? S_COMMIT : S_SHIFT;
      S_COMMIT: state_nxt = S_LOAD;
      default:  state_nxt = S_LOAD;
    endcase
  end

  // Converter FSM: outputs
  always_comb begin
    load_en   = (state == S_LOAD);
    shift_en  = (state == S_SHIFT);
    commit_en = (state == S_COMMIT);
    dbg_state = state;
  end

  always_comb begin
    bcd_adj = bcd;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  // The top nibble's carry falls off the end of the shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bin  <= '0;
      samp <= '0;
      bcd  <= '0;
      cnt  <= '0;
    end else if (load_en) begin
      bin  <= in;
      samp <= in;
      bcd  <= '0;
      cnt  <= CNT_W'(WIDTH);
    end else if (shift_en) begin
      bcd  <= {bcd_adj[BCD_W-2:0], bin[WIDTH-1]};
      bin  <= {bin[WIDTH-2:0], 1'b0};
      cnt  <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    disp_nxt = commit_en ? bcd : disp;
    ovf_nxt  = commit_en ? (64'(samp) > LIMIT) : overflow;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp     <= '0;
      overflow <= 1'b0;
    end else begin
      disp     <= disp_nxt;
      overflow <= ovf_nxt;
    end
  end

  assign tick    = &pre;
  assign idx_nxt = !tick ? idx : ((idx == LAST_IDX) ? '0 : idx + IDX_W'(1));
  assign sel_nxt = ~(DIGITS'(1) << idx_nxt);

`ifdef SEG_LZ_BLANK_EN
  logic [DIGITS-1:0] nz_from;
  logic              nz_run;

  // nz_from[k]: some digit at position k or above is non-zero
  always_comb begin
    nz_run  = 1'b0;
    nz_from = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      nz_run     = nz_run | (disp_nxt[4*k +: 4] != 4'd0);
      nz_from[k] = nz_run;
    end
  end
`endif

  // Built from next-cycle index/display so a COMMIT on a tick edge shows the new value.
  always_comb begin
    nib = disp_nxt[{idx_nxt, 2'b00} +: 4];
    seg = seg7(nib);
`ifdef SEG_LZ_BLANK_EN
    if ((idx_nxt != '0) && !nz_from[idx_nxt]) seg = 7'h7F;
`endif
    out_nxt = ovf_nxt ? 8'hBF : {~dp_mask[idx_nxt], seg};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      idx <= '0;
      sel <= ~DIGITS'(1);
      out <= 8'hFF;
    end else begin
      pre <= pre + DIV_BITS'(1);
      idx <= idx_nxt;
      if (tick) begin
        sel <= sel_nxt;
        out <= out_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display (DIGITS=4, WIDTH=16, DIV_BITS=2): decimal reference model feeding
// an expected queue, a negedge monitor, directed vectors and randomized values.
module tb_seg_scan_display;
  localparam int DIGITS   = 4;
  localparam int WIDTH    = 16;
  localparam int DIV_BITS = 2;
  localparam int PERIOD   = WIDTH + 2;
  localparam int SCAN     = 1 << DIV_BITS;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] in;
  logic [3:0]  dp_mask;
  logic [7:0]  out;
  logic [3:0]  sel;
  logic        overflow;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  int         ecnt    = 0;
  int         samp_v  = 0;
  int         disp_v  = 0;
  logic       exp_ovf = 1'b0;
  logic [11:0] exp_q[$];
  int          exp_t_q[$];
  logic [11:0] cur_exp = 12'hEFF;

  logic [7:0] seg_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  seg_scan_display #(.DIGITS(DIGITS), .WIDTH(WIDTH), .DIV_BITS(DIV_BITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .dp_mask   (dp_mask),
    .out       (out),
    .sel       (sel),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Decimal view of the committed value: digit k is (v / 10^k) % 10.
  function automatic logic [11:0] model_word(input int v, input int k, input logic [3:0] dp);
    int         p;
    logic [7:0] o;
    logic [3:0] s;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (v > 9999) begin
      o = 8'hBF;
    end else begin
      o = {~dp[k], seg_tab[(v / p) % 10][6:0]};
`ifdef SEG_LZ_BLANK_EN
      if ((k > 0) && (v < p)) o[6:0] = 7'h7F;
`endif
    end
    s = 4'b1111;
    s[k] = 1'b0;
    return {s, o};
  endfunction

  // reference model: counts edges since reset release and pushes one entry per digit step
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      ecnt    = 0;
      samp_v  = 0;
      disp_v  = 0;
      exp_ovf = 1'b0;
      exp_q.delete();
      exp_t_q.delete();
    end else begin
      ecnt++;
      if (ecnt % PERIOD == 1) samp_v = int'(in);
      if (ecnt % PERIOD == 0) begin
        disp_v  = samp_v;
        exp_ovf = (disp_v > 9999);
      end
      if (ecnt % SCAN == 0) begin
        exp_q.push_back(model_word(disp_v, (ecnt / SCAN) % DIGITS, dp_mask));
        exp_t_q.push_back(ecnt);
      end
    end
  end

  // monitor: pops entries that are due and checks the held display every cycle
  initial forever begin
    @(negedge clk or negedge rst);
    if (!rst) begin
      cur_exp = {4'b1110, 8'hFF};
    end else begin
      while (exp_t_q.size() > 0 && exp_t_q[0] <= ecnt) begin
        cur_exp = exp_q.pop_front();
        void'(exp_t_q.pop_front());
      end
      check("scan", 32'({sel, out}), 32'(cur_exp));
      check("ovf", 32'(overflow), 32'(exp_ovf));
    end
  end

  // Waits for the start of digit 0, then checks all four digits over one full scan.
  task automatic check_scan(input string nm, input logic [31:0] codes);
    int guard = 0;
    while (sel == 4'b1110 && guard < 64) begin @(negedge clk); guard++; end
    while (sel != 4'b1110 && guard < 64) begin @(negedge clk); guard++; end
    check({nm, "_align"}, 32'(guard < 64), 32'd1);
    for (int d = 0; d < 4; d++) begin
      for (int c = 0; c < SCAN; c++) begin
        check(nm, 32'({sel, out}), 32'({~(4'b0001 << d), codes[8*d +: 8]}));
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int guard;
    rst     = 1'b0;
    in      = 16'd1234;
    dp_mask = 4'b0000;
    #12;
    check("rst_out", 32'(out), 32'hFF);
    check("rst_sel", 32'(sel), 32'hE);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // input changes three cycles after LOAD: old value shown until the next COMMIT
    wait_cycles(3);
    in = 16'd5678;
    wait_cycles(17);
    check("hold_old", 32'({sel, out}), 32'({4'b1101, 8'hB0}));
    wait_cycles(20);
    check("show_new", 32'({sel, out}), 32'({4'b1011, 8'h82}));

    in = 16'd1234;
    wait_cycles(40);
    check_scan("v1234", 32'hF9A4B099);
    dp_mask = 4'b0010;
    wait_cycles(10);
    check_scan("dp1", 32'hF9A43099);
    dp_mask = 4'b0000;
    in = 16'd10000;
    wait_cycles(40);
    check("ovf_set", 32'(overflow), 32'd1);
    check_scan("v10000", 32'hBFBFBFBF);
    in = 16'd9999;
    wait_cycles(40);
    check("ovf_clr", 32'(overflow), 32'd0);
    check_scan("v9999", 32'h90909090);
    in = 16'd7;
    wait_cycles(40);
`ifdef SEG_LZ_BLANK_EN
    check_scan("v7", 32'hFFFFFFF8);
`else
    check_scan("v7", 32'hC0C0C0F8);
`endif
    in = 16'd0;
    dp_mask = 4'b1001;
    wait_cycles(40);
`ifdef SEG_LZ_BLANK_EN
    check_scan("v0", 32'h7FFFFF40);
`else
    check_scan("v0", 32'h40C0C040);
`endif
    dp_mask = 4'b1111;
    in = 16'hFFFF;
    wait_cycles(40);
    check_scan("vmax", 32'hBFBFBFBF);

    // randomized values, checked by the monitor against the model
    repeat (40) begin
      case ($urandom_range(0, 3))
        0: in = 16'($urandom_range(0, 65535));
        1: in = 16'($urandom_range(0, 9999));
        2: in = 16'($urandom_range(0, 99));
        default: in = 16'($urandom_range(9990, 10010));
      endcase
      dp_mask = 4'($urandom_range(0, 15));
      wait_cycles($urandom_range(3, 60));
    end

    // reset in mid-SHIFT while a non-zero digit is selected and overflow is set
    in = 16'd10000;
    dp_mask = 4'b0101;
    guard = 0;
    while (!((ecnt % PERIOD == 10) && (((ecnt / SCAN) % DIGITS) != 0) && exp_ovf) && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    check("midshift_reach", 32'(guard < 600), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_out", 32'(out), 32'hFF);
    check("arst_sel", 32'(sel), 32'hE);
    check("arst_ovf", 32'(overflow), 32'd0);
    check("arst_state", 32'(dbg_state), 32'd0);
    wait_cycles(2);
    rst = 1'b1;
    wait_cycles(17);
    check("commit_before", 32'(overflow), 32'd0);
    wait_cycles(1);
    check("commit_at_18", 32'(overflow), 32'd1);

    wait_cycles(8);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Interface
REQ-001 Parameter DIGITS, default 4: number of multiplexed 7-segment digits, legal 1..8.
REQ-002 Parameter WIDTH, default 16: binary input width, legal 4..32.
REQ-003 Parameter DIV_BITS, default 16: scan prescaler width; digit period = 2^DIV_BITS clk cycles.
REQ-004 clk  input  1: single clock, all state on rising edge.
REQ-005 rst  input  1: asynchronous, active-low reset.
REQ-006 in  input  WIDTH: unsigned binary value to display.
REQ-007 dp_mask  input  DIGITS: bit i=1 lights decimal point of digit i.
REQ-008 out  output  8: active-low segments, bit7=dp, bits6..0 = g..a.
REQ-009 sel  output  DIGITS: active-low one-hot digit enable; sel[0] = least significant digit.
REQ-010 overflow  output  1: high while the displayed value exceeds 10^DIGITS-1.

Function
REQ-011 Converter SHALL run a free-running FSM LOAD -> SHIFT -> COMMIT -> LOAD, with no idle state.
REQ-012 In LOAD, the converter SHALL sample in into a shift register, clear the 4*DIGITS-bit BCD accumulator and set bit count = WIDTH.
REQ-013 In SHIFT, one double-dabble step per cycle: add 3 to each nibble >= 5, then shift left one bit taking the binary MSB; after WIDTH steps go to COMMIT.
REQ-014 Carries out of the top BCD nibble SHALL be discarded.
REQ-015 In COMMIT, the converter SHALL copy the accumulator to the display register and set overflow = (sampled value > 10^DIGITS-1) in the same edge.
REQ-016 Conversion period SHALL be WIDTH+2 cycles; changes on in after LOAD SHALL NOT affect the display until the following COMMIT.
REQ-017 Prescaler: DIV_BITS-bit counter increments every cycle and wraps to 0; tick = counter all-ones.
REQ-018 On tick, digit index SHALL advance 0,1,...,DIGITS-1,0 (wrap).
REQ-019 sel and out SHALL be registered and update on the same edge as the index, so they are always mutually consistent.
REQ-020 Digit codes for 0..9 SHALL be C0,F9,A4,B0,99,92,82,F8,80,90 (hex) in bits6..0; nibble values 10..15 SHALL give 7F (all segments off).
REQ-021 out[7] SHALL equal ~dp_mask[index] for every non-overflow digit.
REQ-022 While overflow=1, every digit SHALL show BF (segment g only; dp off), regardless of dp_mask.
REQ-023 The display register and overflow SHALL change only at COMMIT; a COMMIT coinciding with tick SHALL use the new display register for the newly selected digit.

Reset
REQ-024 With rst low, the block SHALL immediately force: FSM=LOAD, prescaler=0, index=0, sel=~1 (only digit 0 enabled), out=FF, display register=0, overflow=0.
REQ-025 Reset asserted mid-SHIFT SHALL discard the partial conversion; the first COMMIT after release SHALL occur WIDTH+2 cycles after the first clk edge with rst high.

Configuration
REQ-026 Macro SEG_LZ_BLANK_EN defined: digits above the most significant non-zero digit SHALL output bits6..0 = 7F; dp SHALL still follow dp_mask; digit 0 is never blanked; blanking is suppressed while overflow=1.
REQ-027 Macro SEG_LZ_BLANK_EN undefined: all digits SHALL display their BCD value including leading zeros; no blanking logic SHALL be built.

Verification (DIGITS=4, WIDTH=16, DIV_BITS=2 unless stated)
REQ-028 in=1234, dp_mask=0, after first COMMIT -> sel 1110/1101/1011/0111 with out 99/B0/A4/F9, each held 4 cycles, overflow=0.
REQ-029 in=10000 -> after COMMIT overflow=1 and all four digits out=BF; then in=9999 -> next COMMIT overflow=0, every digit out=90.
REQ-030 in=7: with SEG_LZ_BLANK_EN -> digit0 F8, digits1..3 FF; without the macro -> digit0 F8, digits1..3 C0.
REQ-031 in=1234, dp_mask=0010 -> digit1 out=30, all other digits keep dp off (bit7=1).
REQ-032 in changed 1234 -> 5678 three cycles after LOAD -> display shows 1234 until the next COMMIT, then 5678 within WIDTH+2 further cycles.
REQ-033 rst pulled low mid-SHIFT and mid-digit, with no clk edge -> out=FF, sel=1110 and overflow=0 immediately; after release, first COMMIT occurs exactly 18 cycles later.
